// File: rtl/gate_net_pipe.sv
// gate_net_pipe: WIDTH-lane pipelined evaluation of the six-input gate netlist
//   t1 = ~(a & b), t2 = c & ~b & d, t3 = ~(e | f), y = mode ? (t1&t2&t3) : ~(t1&t2&t3)
// Stage 1 registers t1/t2/t3 and mode, stage 2 registers y, later stages delay y.
// Valid/ready flow control collapses bubbles; ready is a combinational chain
// from out_ready_i back to in_ready_o. A saturating counter accumulates the
// number of set y bits over every transferred output beat.
module gate_net_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] e_i,
    input  logic [WIDTH-1:0] f_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    input  logic             clr_count_i,
    output logic [CNT_W-1:0] hit_count_o
);

    // Popcount width at full precision, and a sum wide enough to never wrap.
    localparam int unsigned PcW     = $clog2(WIDTH + 1);
    localparam int unsigned SumW    = ((CNT_W > PcW) ? CNT_W : PcW) + 1;
    // Number of stages that hold y (stage 2 .. STAGES).
    localparam int unsigned YStages = STAGES - 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Per-stage valid flags; bit 0 is stage 1, bit STAGES-1 is the output stage.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    // rdy[k]: stage k can take a new beat this cycle.
    logic [STAGES-1:0] rdy;

    // Stage 1 data.
    logic [WIDTH-1:0] t1_q, t1_d;
    logic [WIDTH-1:0] t2_q, t2_d;
    logic [WIDTH-1:0] t3_q, t3_d;
    logic             mode_q, mode_d;
    logic             s1_load;

    // Stage 2 .. STAGES data; index 0 is stage 2.
    logic [WIDTH-1:0] y_q [YStages];
    logic [WIDTH-1:0] y_d [YStages];
    logic [YStages-1:0] y_load;
    logic [WIDTH-1:0] y_new;

    // Hit counter.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PcW-1:0]   pc;
    logic [SumW-1:0]  sum;
    logic             out_xfer;

    // Ready chain: a stage is ready when empty or when the stage after it is ready.
    always_comb begin
        logic r;
        r = out_ready_i;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r = ~v_q[k] | r;
            rdy[k] = r;
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v_q[STAGES-1];
    assign y_o         = y_q[YStages-1];
    assign hit_count_o = cnt_q;

    // Valid flags move forward whenever the receiving stage is ready.
    always_comb begin
        v_d = v_q;
        if (rdy[0]) begin
            v_d[0] = in_valid_i;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    // Stage 1 captures the three intermediate terms and the beat's mode.
    always_comb begin
        s1_load = rdy[0] & in_valid_i;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        mode_d  = mode_q;
        if (s1_load) begin
            t1_d   = ~(a_i & b_i);
            t2_d   = c_i & ~b_i & d_i;
            t3_d   = ~(e_i | f_i);
            mode_d = mode_i;
        end
    end

    // Final gate uses the mode that travelled with the beat, not the live input.
    always_comb begin
        if (mode_q) begin
            y_new = t1_q & t2_q & t3_q;
        end else begin
            y_new = ~(t1_q & t2_q & t3_q);
        end
    end

    // y stages load only when the upstream slot holds a beat; otherwise hold.
    always_comb begin
        y_load    = '0;
        y_load[0] = rdy[1] & v_q[0];
        y_d[0]    = y_load[0] ? y_new : y_q[0];
        for (int j = 1; j < YStages; j++) begin
            y_load[j] = rdy[j+1] & v_q[j];
            y_d[j]    = y_load[j] ? y_q[j-1] : y_q[j];
        end
    end

    // Popcount of the presented output beat, kept at full precision.
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PcW'(y_o[i]);
        end
    end

    // Saturating accumulate on output transfer; clear wins over a coincident transfer.
    always_comb begin
        out_xfer = v_q[STAGES-1] & out_ready_i;
        sum      = SumW'(cnt_q) + SumW'(pc);
        cnt_d    = cnt_q;
        if (clr_count_i) begin
            cnt_d = '0;
        end else if (out_xfer) begin
            if (sum > SumW'(CntMax)) begin
                cnt_d = CntMax;
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    // State registers; reset drops every in-flight beat and clears outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
            t3_q   <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            for (int j = 0; j < YStages; j++) begin
                y_q[j] <= '0;
            end
        end else begin
            v_q    <= v_d;
            t1_q   <= t1_d;
            t2_q   <= t2_d;
            t3_q   <= t3_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            for (int j = 0; j < YStages; j++) begin
                y_q[j] <= y_d[j];
            end
        end
    end

endmodule

// File: doc/gate_net_pipe.md
# gate_net_pipe

Parametrised, pipelined, multi-lane successor to the team's single-bit six-input gate netlist. Each of WIDTH independent lanes evaluates t1 = ~(A&B), t2 = C&~B&D, t3 = ~(E|F), Y = ~(t1&t2&t3). A mode bit selects the true or inverted final gate. The block is registered over STAGES cycles with valid/ready flow control and a saturating count of asserted output bits. It sits between a stimulus/source block and downstream consumers wherever the netlist function is needed at clock rate.

## Interface
- WIDTH, 8, number of independent lanes (1..64)
- STAGES, 2, pipeline depth in cycles (2..8); stage 1 holds t1/t2/t3, stage 2 holds y, stages 3..STAGES are delay
- CNT_W, 16, width of hit counter (4..32)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- a, b, c, d, e, f  in  WIDTH each  lane operands, bit i belongs to lane i
- mode  in  1  0: y = NAND(t1,t2,t3); 1: y = AND(t1,t2,t3); sampled with the beat
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts beat
- y  out  WIDTH  lane results
- clr_count  in  1  synchronous clear of hit_count
- hit_count  out  CNT_W  saturating sum of popcount(y) over all transferred output beats

## Operation
- Transfer on a port occurs when valid & ready are both high at a rising edge.
- Each stage k has a valid flag v[k] and data register. Stage k loads when it is empty or when stage k+1 advances. The last stage advances on out_ready. This collapses bubbles, so a beat never waits behind an empty slot.
- in_ready = ~v[1] | stage 1 advancing. This is a combinational ready chain from out_ready; no registered skid.
- Stage 1 captures t1, t2, t3 (WIDTH each) and mode. Stage 2 computes y from the stage-1 registers and the stage-1 mode. Later stages copy y unchanged.
- mode travels with its beat, so changing mode while beats are in flight does not alter them.
- Data registers hold their value when not loading. y is only meaningful while out_valid = 1.
- hit_count:
  - On an output transfer, hit_count <= min(hit_count + popcount(y), 2^CNT_W - 1).
  - popcount is computed at full precision (clog2(WIDTH+1) bits) before saturation.
- clr_count = 1 forces hit_count <= 0 on the next edge. clr_count has priority over a simultaneous transfer; the beat's bits are not counted.
- Reset (asynchronous assert, synchronous-release expected from system):
  - all v[k] = 0, out_valid = 0
  - y = 0, hit_count = 0
  - in_ready = 1 combinationally once rst_n is high
- Reset mid-stream discards every in-flight beat; no partial output is produced.

## Timing
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES-1. It transfers at the earliest at edge n+STAGES, given out_ready held high.
- Throughput: one beat per cycle while out_ready = 1.
- Back-pressure:
  - With out_ready = 0, the pipe absorbs up to STAGES beats, then in_ready drops in the same cycle the last slot fills.
  - Raising out_ready raises in_ready combinationally in that same cycle.
- out_valid and y change only on rising edges or on reset assertion. hit_count updates one edge after the counted transfer.
- No combinational path from in_valid or operands to the outputs. The only combinational path is out_ready -> in_ready.

## Test plan
- Reset values: assert rst_n = 0 mid-cycle with the pipe full -> immediately out_valid = 0, y = 0, hit_count = 0; after release, in_ready = 1.
- Function, WIDTH = 4, STAGES = 2, mode 0:
  - a = 0000, b = 0000, c = 1111, d = 1111, e = 0000, f = 0000 -> y = 0000, with out_valid high one edge after acceptance.
  - a = 1111, b = 1111, others 0 -> y = 1111.
- Mode tracking: back-to-back beats with the first operand set, mode = 0 then mode = 1 -> y = 0000 then 1111 on consecutive cycles, hit_count = 4.
- Back-pressure, STAGES = 3: hold out_ready = 0 and stream 5 beats -> exactly 3 accepted and in_ready = 0. Release out_ready -> beats emerge in order, none lost or duplicated.
- Saturation, CNT_W = 4, WIDTH = 4: 4 beats of y = 1111 -> hit_count = 15, not 16. clr_count coincident with a transfer -> hit_count = 0.
- Random stream, 10k beats with random in_valid/out_ready -> outputs match a reference model in order, and hit_count matches the model sum (saturated).
